// File: rtl/sys_defs.sv
// Shared definitions for the rename stage: register-file sizes, derived
// widths, the physical tag record carried to the reservation station, and
// small helpers used by the map table and free list.
package sys_defs;

  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int TAG_W     = $clog2(PHYS_REGS);
  localparam int AREG_W    = $clog2(ARCH_REGS);

  // The free list holds every physical register not architecturally mapped.
  localparam int FL_DEPTH  = PHYS_REGS - ARCH_REGS;
  localparam int FL_PTR_W  = $clog2(FL_DEPTH);
  localparam int FL_CNT_W  = $clog2(FL_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             ready;
  } phys_tag_t;

  // Circular pointer advance; written out so a non-power-of-two depth wraps too.
  function automatic logic [FL_PTR_W-1:0] fl_next_ptr(input logic [FL_PTR_W-1:0] p);
    if (p == FL_PTR_W'(FL_DEPTH - 1)) begin
      return '0;
    end
    return p + FL_PTR_W'(1);
  endfunction

  // A producer completing on the CDB this cycle makes its consumers ready now.
  function automatic phys_tag_t cdb_bypass(input phys_tag_t e, input logic cdb_valid,
                                           input logic [TAG_W-1:0] cdb_tag);
    phys_tag_t r;
    r = e;
    if (cdb_valid && (e.tag == cdb_tag)) begin
      r.ready = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rename_map_free_list.sv
// Circular FIFO of free physical tags.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   alloc_i        : pop the head tag (ignored when empty)
//   free_i         : push free_tag_i at the tail (ignored when full)
//   free_tag_i     : tag being returned
//   head_tag_o     : tag that the next allocation will receive
//   empty_o        : no tags available
//   full_o         : every non-architectural tag is already free
// A tag pushed in a cycle is written at the tail and cannot appear at the
// head output until the following cycle, so it is never reallocated at once.
module free_list
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_i,
  input  logic             free_i,
  input  logic [TAG_W-1:0] free_tag_i,
  output logic [TAG_W-1:0] head_tag_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [TAG_W-1:0]    slots_q [FL_DEPTH];
  logic [FL_PTR_W-1:0] head_q, head_d;
  logic [FL_PTR_W-1:0] tail_q, tail_d;
  logic [FL_CNT_W-1:0] count_q, count_d;
  logic                do_alloc, do_free;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FL_CNT_W'(FL_DEPTH));
  assign head_tag_o = slots_q[head_q];
  assign do_alloc   = alloc_i && !empty_o;
  assign do_free    = free_i && !full_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_alloc) head_d = fl_next_ptr(head_q);
    if (do_free)  tail_d = fl_next_ptr(tail_q);
    case ({do_free, do_alloc})
      2'b10:   count_d = count_q + FL_CNT_W'(1);
      2'b01:   count_d = count_q - FL_CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        slots_q[i] <= TAG_W'(ARCH_REGS + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FL_CNT_W'(FL_DEPTH);
    end else begin
      if (do_free) slots_q[tail_q] <= free_tag_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Returning a tag while every tag is already free means the ROB freed
  // something twice; the push is dropped above.
  a_no_free_when_full: assert property (@(posedge clock) disable iff (reset)
    !(free_i && full_o));

endmodule

// File: rtl/rename_map.sv
// R10K-style rename stage: map table with ready bits plus free list.
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   dispatch_valid       : decoded instruction offered this cycle
//   has_dest, dest_reg   : destination write and its architectural register
//   src1_reg, src2_reg   : architectural sources
//   rs_stall             : reservation station cannot take an instruction
//   cdb_valid, cdb_tag   : completing physical tag, sets ready bits
//   retire_valid/_told   : ROB returns a previous mapping to the free list
//   dispatch_ok          : instruction accepted this cycle (combinational)
//   out_valid            : one-cycle pulse, T/T1/T2/Told are fresh
//   T, T1, T2            : {tag, ready} for destination and sources
//   Told                 : previous mapping of dest_reg for the ROB
//   free_empty           : no physical tags left to allocate
// Handshake: an instruction transfers on a cycle where dispatch_valid and
// dispatch_ok are both high; dispatch_ok never depends on a tag freed in the
// same cycle. Results appear one cycle later with out_valid, and hold when
// nothing is accepted.
module rename_map
  import sys_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              dispatch_valid,
  input  logic              has_dest,
  input  logic [AREG_W-1:0] dest_reg,
  input  logic [AREG_W-1:0] src1_reg,
  input  logic [AREG_W-1:0] src2_reg,
  input  logic              rs_stall,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic              retire_valid,
  input  logic [TAG_W-1:0]  retire_told,
  output logic              dispatch_ok,
  output logic              out_valid,
  output phys_tag_t         T,
  output phys_tag_t         T1,
  output phys_tag_t         T2,
  output logic [TAG_W-1:0]  Told,
  output logic              free_empty
);

  localparam phys_tag_t ZERO_READY = '{tag: '0, ready: 1'b1};

  phys_tag_t        map_q [ARCH_REGS];
  phys_tag_t        map_d [ARCH_REGS];
  phys_tag_t        t_q, t_d, t1_q, t1_d, t2_q, t2_d;
  logic [TAG_W-1:0] told_q, told_d;
  logic             out_valid_q;

  logic             need_dest, alloc;
  logic [TAG_W-1:0] fl_head_tag;
  logic             fl_empty, fl_full;
  logic             fl_free;

  assign need_dest   = has_dest && (dest_reg != '0);
  assign dispatch_ok = dispatch_valid && !rs_stall && (!need_dest || !fl_empty);
  assign alloc       = dispatch_ok && need_dest;
  // r0 is never renamed, so its tag 0 must never enter the free list.
  assign fl_free     = retire_valid && (retire_told != '0);

  free_list u_free_list (
    .clock      (clock),
    .reset      (reset),
    .alloc_i    (alloc),
    .free_i     (fl_free),
    .free_tag_i (retire_told),
    .head_tag_o (fl_head_tag),
    .empty_o    (fl_empty),
    .full_o     (fl_full)
  );

  // Map update: CDB wakeup first, then the new allocation overrides it so a
  // freshly renamed destination is never marked ready by a stale broadcast.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      map_d[i] = cdb_bypass(map_q[i], cdb_valid, cdb_tag);
    end
    if (alloc) begin
      map_d[dest_reg] = '{tag: fl_head_tag, ready: 1'b0};
    end
  end

  // Sources read the map before this cycle's update, so rX <- rX + ... sees
  // the older producer.
  always_comb begin
    t_d    = t_q;
    t1_d   = t1_q;
    t2_d   = t2_q;
    told_d = told_q;
    if (dispatch_ok) begin
      t1_d = (src1_reg == '0) ? ZERO_READY : cdb_bypass(map_q[src1_reg], cdb_valid, cdb_tag);
      t2_d = (src2_reg == '0) ? ZERO_READY : cdb_bypass(map_q[src2_reg], cdb_valid, cdb_tag);
      if (need_dest) begin
        t_d    = '{tag: fl_head_tag, ready: 1'b0};
        told_d = map_q[dest_reg].tag;
      end else begin
        t_d    = ZERO_READY;
        told_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= '{tag: TAG_W'(i), ready: 1'b1};
      end
      t_q         <= '0;
      t1_q        <= '0;
      t2_q        <= '0;
      told_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      map_q       <= map_d;
      t_q         <= t_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      told_q      <= told_d;
      out_valid_q <= dispatch_ok;
    end
  end

  assign out_valid  = out_valid_q;
  assign T          = t_q;
  assign T1         = t1_q;
  assign T2         = t2_q;
  assign Told       = told_q;
  assign free_empty = fl_empty;

  // Full state is only observable through the assertion inside the free list.
  logic unused_full;
  assign unused_full = fl_full;

endmodule

// File: tb/tb_rename_map.sv
module tb_rename_map;
  import sys_defs::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              dispatch_valid = 0, has_dest = 0, rs_stall = 0;
  logic [AREG_W-1:0] dest_reg = 0, src1_reg = 0, src2_reg = 0;
  logic              cdb_valid = 0, retire_valid = 0;
  logic [TAG_W-1:0]  cdb_tag = 0, retire_told = 0;
  logic              dispatch_ok, out_valid, free_empty;
  phys_tag_t         T, T1, T2;
  logic [TAG_W-1:0]  Told;

  rename_map dut (
    .clock(clock), .reset(reset),
    .dispatch_valid(dispatch_valid), .has_dest(has_dest), .dest_reg(dest_reg),
    .src1_reg(src1_reg), .src2_reg(src2_reg), .rs_stall(rs_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .retire_valid(retire_valid), .retire_told(retire_told),
    .dispatch_ok(dispatch_ok), .out_valid(out_valid),
    .T(T), .T1(T1), .T2(T2), .Told(Told), .free_empty(free_empty)
  );

  // ---------------- reference model ----------------
  int          map_tag [ARCH_REGS];
  bit          map_rdy [ARCH_REGS];
  int          fl [$];        // free tags, oldest first
  int          pending [$];   // Told values awaiting retirement, in order
  logic [26:0] exp_q [$];     // {T, T1, T2, Told}
  logic [26:0] exp_out;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ARCH_REGS; i++) begin
      map_tag[i] = i;
      map_rdy[i] = 1'b1;
    end
    fl.delete();
    for (int i = ARCH_REGS; i < PHYS_REGS; i++) fl.push_back(i);
    pending.delete();
    exp_q.delete();
    exp_out = '0;
  endtask

  function automatic logic [6:0] src_view(input int r, input bit cv, input int ct);
    if (r == 0) return {6'd0, 1'b1};
    return {6'(map_tag[r]), map_rdy[r] | (cv && (ct == map_tag[r]))};
  endfunction

  task automatic check_outputs();
    check("T",    32'(T),    32'(exp_out[26:20]));
    check("T1",   32'(T1),   32'(exp_out[19:13]));
    check("T2",   32'(T2),   32'(exp_out[12:6]));
    check("Told", 32'(Told), 32'(exp_out[5:0]));
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic drive_cycle(input bit dv, input bit hd, input int dst, input int s1, input int s2,
                             input bit st, input bit cv, input int ct, input bit rv, input int rt);
    bit need, acc;
    int pre_size;
    logic [6:0] t, t1, t2;
    logic [5:0] told;
    dispatch_valid = dv; has_dest = hd; dest_reg = AREG_W'(dst);
    src1_reg = AREG_W'(s1); src2_reg = AREG_W'(s2); rs_stall = st;
    cdb_valid = cv; cdb_tag = TAG_W'(ct); retire_valid = rv; retire_told = TAG_W'(rt);
    pre_size = fl.size();
    need = hd && (dst != 0);
    acc  = dv && !st && (!need || pre_size != 0);
    #1;
    check("dispatch_ok", 32'(dispatch_ok), 32'(acc));
    check("free_empty",  32'(free_empty),  32'(pre_size == 0));
    if (acc) begin
      t1 = src_view(s1, cv, ct);
      t2 = src_view(s2, cv, ct);
      if (need) begin
        t = {6'(fl[0]), 1'b0};
        told = 6'(map_tag[dst]);
      end else begin
        t = {6'd0, 1'b1};
        told = 6'd0;
      end
      exp_q.push_back({t, t1, t2, told});
    end
    if (cv) for (int i = 0; i < ARCH_REGS; i++) if (map_tag[i] == ct) map_rdy[i] = 1'b1;
    if (acc && need) begin
      pending.push_back(map_tag[dst]);
      map_tag[dst] = fl.pop_front();
      map_rdy[dst] = 1'b0;
    end
    if (rv && rt != 0 && pre_size < FL_DEPTH) fl.push_back(rt);
    @(posedge clock);
    #1;
    check("out_valid", 32'(out_valid), 32'(acc));
    if (acc) exp_out = exp_q.pop_front();
    check_outputs();
    dispatch_valid = 0; cdb_valid = 0; retire_valid = 0; rs_stall = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dispatch_valid = 1; has_dest = 1; dest_reg = 5'd7; src1_reg = 5'd1; src2_reg = 5'd2;
    retire_valid = 0; cdb_valid = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    dispatch_valid = 0;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_free_empty", 32'(free_empty), 32'd0);
    check_outputs();
  endtask

  task automatic random_cycles(input int n);
    bit rv;
    int rt;
    for (int k = 0; k < n; k++) begin
      rv = 0; rt = 0;
      if (pending.size() != 0 && $urandom_range(0, 3) == 0) begin
        rv = 1; rt = pending.pop_front();
      end else if ($urandom_range(0, 15) == 0) begin
        rv = 1; rt = 0;   // tag 0 returned: must be ignored
      end
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, PHYS_REGS - 1), rv, rt);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rt;
    model_reset();
    do_reset();

    // r3 <- r1 + r2
    drive_cycle(1, 1, 3, 1, 2, 0, 0, 0, 0, 0);
    check("d1_T", 32'(T), 32'({6'd32, 1'b0}));
    check("d1_T1", 32'(T1), 32'({6'd1, 1'b1}));
    check("d1_Told", 32'(Told), 32'd3);
    // r4 <- r3 + r3
    drive_cycle(1, 1, 4, 3, 3, 0, 0, 0, 0, 0);
    check("d2_T2", 32'(T2), 32'({6'd32, 1'b0}));
    // r5 <- r3 + r0 while tag 32 completes
    drive_cycle(1, 1, 5, 3, 0, 0, 1, 32, 0, 0);
    check("d3_T1", 32'(T1), 32'({6'd32, 1'b1}));
    check("d3_T2", 32'(T2), 32'({6'd0, 1'b1}));
    // later read of r3 keeps ready
    drive_cycle(1, 1, 6, 3, 1, 0, 0, 0, 0, 0);
    check("d4_T1", 32'(T1), 32'({6'd32, 1'b1}));

    // drain the free list (4 used, 28 more)
    for (int k = 0; k < 28; k++)
      drive_cycle(1, 1, $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  0, 0, 0, 0, 0);
    drive_cycle(1, 1, 9, 1, 2, 0, 0, 0, 0, 0);   // 33rd: rejected
    check("full_no_valid", 32'(out_valid), 32'd0);
    rt = pending.pop_front();                      // oldest Told, r3's old tag 3
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, rt);
    drive_cycle(1, 1, 7, 1, 2, 0, 0, 0, 0, 0);
    check("refill_T", 32'(T), 32'({6'd3, 1'b0}));

    // rs_stall blocks dispatch
    drive_cycle(1, 1, 8, 1, 2, 1, 0, 0, 0, 0);
    check("stall_no_valid", 32'(out_valid), 32'd0);

    random_cycles(300);

    // mid-stream reset after 5 renames
    do_reset();
    for (int k = 0; k < 5; k++)
      drive_cycle(1, 1, $urandom_range(1, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  0, 0, 0, 0, 0);
    do_reset();
    drive_cycle(1, 1, 3, 1, 2, 0, 0, 0, 0, 0);
    check("post_rst_T", 32'(T), 32'({6'd32, 1'b0}));
    check("post_rst_T1", 32'(T1), 32'({6'd1, 1'b1}));

    random_cycles(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
